// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch slice.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 8;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;
    localparam logic [5:0]         OP_HALT  = 6'b111111;

    typedef enum logic {
        IDLE,
        LOADING
    } load_state_t;

endpackage

// File: rtl/instr_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words
// and emits one memory write per completed word while write_en is held.
module instr_loader
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         write_en,
    input  logic         load_valid,
    input  logic [7:0]   load_byte,
    output logic         mem_we,
    output logic [5:0]   mem_addr,
    output logic [31:0]  mem_wdata,
    output logic [6:0]   words_loaded,
    output logic         load_overflow
);

    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    load_state_t state, state_nx;
    logic [1:0]  byte_cnt, byte_cnt_nx;
    logic [23:0] asm_q, asm_nx;
    logic [6:0]  words_nx;
    logic        overflow_nx;

    // Loader state and counters; a restart happens only on the IDLE->LOADING transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            asm_q         <= '0;
            words_loaded  <= '0;
            load_overflow <= 1'b0;
        end else begin
            state         <= state_nx;
            byte_cnt      <= byte_cnt_nx;
            asm_q         <= asm_nx;
            words_loaded  <= words_nx;
            load_overflow <= overflow_nx;
        end
    end

    // Next-state, byte packing and write strobe; the 4th byte goes straight to memory.
    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        asm_nx      = asm_q;
        words_nx    = words_loaded;
        overflow_nx = load_overflow;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                byte_cnt_nx = '0;
                if (write_en) begin
                    state_nx    = LOADING;
                    words_nx    = '0;
                    overflow_nx = 1'b0;
                end
            end
            LOADING: begin
                if (!write_en) begin
                    state_nx    = IDLE;
                    byte_cnt_nx = '0;
                end else if (load_valid) begin
                    if (byte_cnt == 2'd3) begin
                        byte_cnt_nx = '0;
                        if (words_loaded < DEPTH_W) begin
                            mem_we   = 1'b1;
                            words_nx = words_loaded + 7'd1;
                        end else begin
                            overflow_nx = 1'b1;
                        end
                    end else begin
                        byte_cnt_nx = byte_cnt + 2'd1;
                        asm_nx      = {asm_q[15:0], load_byte};
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr  = words_loaded[5:0];
    assign mem_wdata = {asm_q, load_byte};

endmodule

// File: rtl/if_id_fetch.sv
// IF-stage fetch: instruction memory, its byte loader and the IF/ID register.
module if_id_fetch
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [7:0]  pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        write_en,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic [31:0] if_id_instr,
    output logic [7:0]  if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [6:0]  words_loaded,
    output logic        load_overflow
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [6:0]  DEPTH_W = 7'(DEPTH);

    logic [31:0] mem [DEPTH];
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [5:0]  word_idx;
    logic [31:0] fetch_word;
    logic [1:0]  unused_pc_lsb;

    assign unused_pc_lsb = pc[1:0];
    assign word_idx      = pc[7:2];

    instr_loader #(
        .DEPTH(DEPTH)
    ) u_loader (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .words_loaded (words_loaded),
        .load_overflow(load_overflow)
    );

    // Program memory write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr[AW-1:0]] <= mem_wdata;
    end

    // Combinational fetch; addresses past the array return NOP.
    always_comb begin
        fetch_word = NOP_WORD;
        if ({1'b0, word_idx} < DEPTH_W) fetch_word = mem[word_idx[AW-1:0]];
    end

    // IF/ID register: write_en > flush > (stall | halted | !clk_en) hold > load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (write_en) begin
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (flush) begin
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
        end else if (!(stall || halted || !clk_en)) begin
            if_id_instr <= fetch_word;
            if_id_pc4   <= pc + 8'd4;
            if_id_valid <= 1'b1;
            if (fetch_word[31:26] == OP_HALT) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed self-checking bench for if_id_fetch (DEPTH=16).
module tb_if_id_fetch;

    logic        clk = 1'b0;
    logic        reset, clk_en, stall, flush, write_en, load_valid;
    logic [7:0]  pc, load_byte;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc4;
    logic        if_id_valid, halted, load_overflow;
    logic [6:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    if_id_fetch #(
        .DEPTH   (16),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .pc           (pc),
        .stall        (stall),
        .flush        (flush),
        .write_en     (write_en),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .words_loaded (words_loaded),
        .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    function automatic logic [31:0] ovf_word(input int unsigned w);
        return {8'(8'h10 + w), 8'h20, 8'h30, 8'(w)};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got %h exp %h", if_id_instr, 32'h0); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
        total++; if (if_id_pc4 !== 8'h00) begin bad++; $display("FAIL rst_pc4 got %h exp 00", if_id_pc4); end
        total++; if (words_loaded !== 7'd0) begin bad++; $display("FAIL rst_words got %0d exp 0", words_loaded); end
        total++; if ({halted, load_overflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got %b exp 00", {halted, load_overflow}); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_load_basic();
        write_en = 1'b1;
        step();
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        total++; if (words_loaded !== 7'd1) begin bad++; $display("FAIL ld_words_mid got %0d exp 1", words_loaded); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL ld_valid_frozen got %b exp 0", if_id_valid); end
        send_byte(8'hAC); send_byte(8'h01);
        write_en = 1'b0;
        pc       = 8'h00;
        clk_en   = 1'b1;
        step();
        total++; if (words_loaded !== 7'd1) begin bad++; $display("FAIL ld_words_end got %0d exp 1", words_loaded); end
        total++; if (if_id_instr !== 32'h2008_0005) begin bad++; $display("FAIL ld_fetch got %h exp %h", if_id_instr, 32'h2008_0005); end
        total++; if (if_id_pc4 !== 8'h04) begin bad++; $display("FAIL ld_pc4 got %h exp 04", if_id_pc4); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL ld_valid got %b exp 1", if_id_valid); end
    endtask

    task automatic test_overflow();
        write_en = 1'b1;
        step();
        for (int w = 0; w < 16; w++) send_word(ovf_word(w));
        total++; if (words_loaded !== 7'd16) begin bad++; $display("FAIL ovf_full_words got %0d exp 16", words_loaded); end
        total++; if (load_overflow !== 1'b0) begin bad++; $display("FAIL ovf_full_flag got %b exp 0", load_overflow); end
        send_word(ovf_word(16));
        total++; if (words_loaded !== 7'd16) begin bad++; $display("FAIL ovf_words got %0d exp 16", words_loaded); end
        total++; if (load_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b exp 1", load_overflow); end
        write_en = 1'b0;
        pc       = 8'h00;
        step();
        total++; if (load_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b exp 1", load_overflow); end
        total++; if (if_id_instr !== 32'h1020_3000) begin bad++; $display("FAIL ovf_mem0 got %h exp %h", if_id_instr, 32'h1020_3000); end
        pc = 8'd60;
        step();
        total++; if (if_id_instr !== 32'h1F20_300F) begin bad++; $display("FAIL ovf_mem15 got %h exp %h", if_id_instr, 32'h1F20_300F); end
        pc = 8'd64;
        step();
        total++; if ({if_id_instr, if_id_valid, if_id_pc4} !== {32'h0, 1'b1, 8'd68}) begin
            bad++; $display("FAIL oor_fetch got %h/%b/%h exp 00000000/1/44", if_id_instr, if_id_valid, if_id_pc4);
        end
    endtask

    task automatic test_stall_flush();
        pc = 8'h04;
        step();
        total++; if (if_id_instr !== 32'h1120_3001) begin bad++; $display("FAIL sf_pre got %h exp %h", if_id_instr, 32'h1120_3001); end
        stall = 1'b1; flush = 1'b1; pc = 8'h08;
        step();
        total++; if ({if_id_instr, if_id_valid} !== {32'h0, 1'b0}) begin bad++; $display("FAIL sf_flush got %h/%b exp 00000000/0", if_id_instr, if_id_valid); end
        stall = 1'b0; flush = 1'b0;
        step();
        total++; if ({if_id_instr, if_id_pc4} !== {32'h1220_3002, 8'h0C}) begin bad++; $display("FAIL sf_resume got %h/%h exp 12203002/0c", if_id_instr, if_id_pc4); end
        stall = 1'b1; pc = 8'h0C;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({if_id_instr, if_id_pc4, if_id_valid} !== {32'h1220_3002, 8'h0C, 1'b1}) begin
                bad++; $display("FAIL sf_stall%0d got %h/%h/%b exp 12203002/0c/1", i, if_id_instr, if_id_pc4, if_id_valid);
            end
        end
        stall = 1'b0; clk_en = 1'b0;
        step();
        total++; if (if_id_instr !== 32'h1220_3002) begin bad++; $display("FAIL sf_clken got %h exp 12203002", if_id_instr); end
        clk_en = 1'b1;
        step();
        total++; if (if_id_instr !== 32'h1320_3003) begin bad++; $display("FAIL sf_after got %h exp 13203003", if_id_instr); end
    endtask

    task automatic test_halt();
        write_en = 1'b1;
        step();
        total++; if ({words_loaded, load_overflow} !== {7'd0, 1'b0}) begin bad++; $display("FAIL h_restart got %0d/%b exp 0/0", words_loaded, load_overflow); end
        send_word(32'h2008_0005);
        send_word(32'hFC00_0000);
        write_en = 1'b0; pc = 8'h00;
        step();
        total++; if (if_id_instr !== 32'h2008_0005) begin bad++; $display("FAIL h_pre got %h exp 20080005", if_id_instr); end
        pc = 8'h04;
        step();
        total++; if ({if_id_instr, halted, if_id_pc4} !== {32'hFC00_0000, 1'b1, 8'h08}) begin
            bad++; $display("FAIL h_set got %h/%b/%h exp fc000000/1/08", if_id_instr, halted, if_id_pc4);
        end
        pc = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if ({if_id_instr, if_id_pc4, halted} !== {32'hFC00_0000, 8'h08, 1'b1}) begin
                bad++; $display("FAIL h_hold%0d got %h/%h/%b exp fc000000/08/1", i, if_id_instr, if_id_pc4, halted);
            end
        end
        write_en = 1'b1;
        step();
        total++; if ({halted, if_id_instr, if_id_valid, if_id_pc4} !== {1'b0, 32'h0, 1'b0, 8'h00}) begin
            bad++; $display("FAIL h_clear got %b/%h/%b/%h exp 0/00000000/0/00", halted, if_id_instr, if_id_valid, if_id_pc4);
        end
        write_en = 1'b0;
        step();
        total++; if ({if_id_instr, if_id_valid, halted} !== {32'h2008_0005, 1'b1, 1'b0}) begin
            bad++; $display("FAIL h_refetch got %h/%b/%b exp 20080005/1/0", if_id_instr, if_id_valid, halted);
        end
    endtask

    task automatic test_wrap();
        pc = 8'hFC;
        step();
        total++; if ({if_id_instr, if_id_valid, if_id_pc4} !== {32'h0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL wrap got %h/%b/%h exp 00000000/1/00", if_id_instr, if_id_valid, if_id_pc4);
        end
    endtask

    task automatic test_async_reset();
        pc = 8'h00;
        step();
        #2;
        reset = 1'b0;
        #1;
        total++; if ({if_id_instr, if_id_valid, if_id_pc4, halted} !== {32'h0, 1'b0, 8'h00, 1'b0}) begin
            bad++; $display("FAIL arst_ifid got %h/%b/%h/%b exp 00000000/0/00/0", if_id_instr, if_id_valid, if_id_pc4, halted);
        end
        total++; if (words_loaded !== 7'd0) begin bad++; $display("FAIL arst_words got %0d exp 0", words_loaded); end
        #3;
        reset = 1'b1;
        step();
        total++; if (if_id_instr !== 32'h2008_0005) begin bad++; $display("FAIL arst_mem got %h exp 20080005", if_id_instr); end
    endtask

    initial begin
        clk_en = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
        write_en = 1'b0; load_valid = 1'b0; load_byte = '0;
        test_reset();
        test_load_basic();
        test_overflow();
        test_stall_flush();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
